fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 15, maximum REQ-state cycles without MemReady before a fault.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 IRWrite  input  1  control unit requests an instruction fetch into IR.
REQ-006 NextPC  input  1  control unit requests PC <= ResultIn.
REQ-007 AdrSrc  input  1  memory address select: 0 = PC, 1 = ResultIn.
REQ-008 ResultIn  input  32  datapath result bus (next PC / data address).
REQ-009 MemRData  input  32  instruction memory read data.
REQ-010 MemReady  input  1  memory read data valid this cycle.
REQ-011 MemReq  output  1  instruction read request, registered.
REQ-012 Adr  output  32  memory address.
REQ-013 PC  output  32  architectural program counter.
REQ-014 Instr  output  32  instruction register.
REQ-015 Cond / Op / Funct / Rn / Rd  output  4/2/6/4/4  Instr[31:28] / [27:26] / [25:20] / [19:16] / [15:12].
REQ-016 Stall  output  1  freezes control-unit micro-address when high.
REQ-017 Fault  output  1  sticky fetch-timeout flag.

Function
REQ-018 FSM states SHALL be IDLE and REQ only.
REQ-019 IDLE with IRWrite=1 SHALL: go to REQ next edge; latch PendPC <= {ResultIn[31:2],2'b00} and PendValid <= NextPC; leave PC unchanged.
REQ-020 IDLE with IRWrite=0 and NextPC=1 SHALL load PC <= {ResultIn[31:2],2'b00} next edge; PC[1:0] always 0.
REQ-021 MemReq SHALL be 1 exactly while state is REQ; Adr SHALL equal PC while in REQ.
REQ-022 In IDLE, Adr SHALL be AdrSrc ? ResultIn : PC (combinational).
REQ-023 REQ with MemReady=1 SHALL, at that edge: Instr <= MemRData; PC <= PendPC if PendValid; clear PendValid; go to IDLE.
REQ-024 REQ with MemReady=0 SHALL increment an internal wait counter (width clog2(TIMEOUT+1)), cleared on REQ entry.
REQ-025 Counter reaching TIMEOUT with MemReady=0 SHALL: set Fault, go to IDLE, leave Instr and PC unchanged, discard PendPC.
REQ-026 Stall SHALL be combinational: (IDLE & IRWrite) | (REQ & ~MemReady) | Fault.
REQ-027 Minimum fetch latency SHALL be 2 cycles (IRWrite cycle in IDLE + one REQ cycle with MemReady).
REQ-028 IRWrite and NextPC in REQ SHALL be ignored; MemReady in IDLE SHALL be ignored.
REQ-029 While Fault=1, IRWrite and NextPC SHALL be ignored and state SHALL remain IDLE.
REQ-030 Cond/Op/Funct/Rn/Rd SHALL be pure slices of Instr, with no added latency.

Reset
REQ-031 reset SHALL force: PC=RESET_PC, Instr=0, state=IDLE, MemReq=0, Fault=0, PendValid=0, counter=0.
REQ-032 reset asserted in REQ SHALL abandon the fetch; a MemReady arriving after reset SHALL NOT update Instr.
REQ-033 reset SHALL have priority over all other inputs in the same cycle.

Structure
REQ-034 Shared package SHALL hold: fetch_state_t enum (IDLE, REQ), instruction field bit-position constants, default RESET_PC.
REQ-035 Instruction field decode SHALL be one sub-module, instr_fields, purely combinational.
REQ-036 PC, Instr, PendPC, PendValid, counter, Fault and state SHALL be flops in fetch_stage.

Verification
REQ-037 reset; IRWrite=1, NextPC=1, ResultIn=4; MemReady=1 in the first REQ cycle with MemRData=32'hE080_2003 -> MemReq high 1 cycle, Adr=0, then Instr=E0802003, PC=4, Op=0, Funct=6'h08, Rd=2.
REQ-038 MemReady delayed 3 REQ cycles -> Stall high 4 cycles total, PC changes only at the MemReady edge.
REQ-039 IDLE, NextPC=1, IRWrite=0, ResultIn=32'h103 -> PC=32'h100 next cycle; AdrSrc=1 -> Adr=ResultIn.
REQ-040 MemReady never asserted -> Fault=1 after 15 REQ cycles, Stall stuck high, PC/Instr unchanged until reset.
REQ-041 reset during REQ, MemReady pulsed one cycle later -> Instr=0, PC=RESET_PC, MemReq=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int COND_HI  = 31;
  localparam int COND_LO  = 28;
  localparam int OP_HI    = 27;
  localparam int OP_LO    = 26;
  localparam int FUNCT_HI = 25;
  localparam int FUNCT_LO = 20;
  localparam int RN_HI    = 19;
  localparam int RN_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 12;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_instr_fields.sv
// Combinational split of the instruction register into its decode fields.
module instr_fields
  import fetch_stage_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  cond,
  output logic [1:0]  op,
  output logic [5:0]  funct,
  output logic [3:0]  rn,
  output logic [3:0]  rd
);

  assign cond  = instr[COND_HI:COND_LO];
  assign op    = instr[OP_HI:OP_LO];
  assign funct = instr[FUNCT_HI:FUNCT_LO];
  assign rn    = instr[RN_HI:RN_LO];
  assign rd    = instr[RD_HI:RD_LO];

  // Low immediate bits are decoded further down the datapath, not here.
  logic unused_low_bits;
  assign unused_low_bits = ^instr[RD_LO-1:0];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IR, pending-PC handoff and fetch-timeout fault.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IRWrite,
  input  logic        NextPC,
  input  logic        AdrSrc,
  input  logic [31:0] ResultIn,
  input  logic [31:0] MemRData,
  input  logic        MemReady,
  output logic        MemReq,
  output logic [31:0] Adr,
  output logic [31:0] PC,
  output logic [31:0] Instr,
  output logic [3:0]  Cond,
  output logic [1:0]  Op,
  output logic [5:0]  Funct,
  output logic [3:0]  Rn,
  output logic [3:0]  Rd,
  output logic        Stall,
  output logic        Fault
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  fetch_state_t     state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic [31:0]      instr_reg, instr_next;
  logic [31:0]      pend_pc_reg, pend_pc_next;
  logic             pend_valid_reg, pend_valid_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0] wait_cnt_inc;
  logic             fault_reg, fault_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      instr_reg      <= '0;
      pend_pc_reg    <= '0;
      pend_valid_reg <= 1'b0;
      wait_cnt_reg   <= '0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      instr_reg      <= instr_next;
      pend_pc_reg    <= pend_pc_next;
      pend_valid_reg <= pend_valid_next;
      wait_cnt_reg   <= wait_cnt_next;
      fault_reg      <= fault_next;
    end
  end

  assign wait_cnt_inc = wait_cnt_reg + 1'b1;

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    instr_next      = instr_reg;
    pend_pc_next    = pend_pc_reg;
    pend_valid_next = pend_valid_reg;
    wait_cnt_next   = wait_cnt_reg;
    fault_next      = fault_reg;
    case (state_reg)
      IDLE: begin
        // A latched fault locks out the control unit until reset.
        if (!fault_reg) begin
          if (IRWrite) begin
            state_next      = REQ;
            pend_pc_next    = word_align(ResultIn);
            pend_valid_next = NextPC;
            wait_cnt_next   = '0;
          end else if (NextPC) begin
            pc_next = word_align(ResultIn);
          end
        end
      end
      REQ: begin
        if (MemReady) begin
          instr_next      = MemRData;
          if (pend_valid_reg) pc_next = pend_pc_reg;
          pend_valid_next = 1'b0;
          state_next      = IDLE;
        end else begin
          wait_cnt_next = wait_cnt_inc;
          if (wait_cnt_inc == TIMEOUT_CNT) begin
            fault_next      = 1'b1;
            pend_valid_next = 1'b0;
            state_next      = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The address is held on PC for the whole request so memory sees a stable address.
  assign MemReq = (state_reg == REQ);
  assign Adr    = (state_reg == REQ) ? pc_reg : (AdrSrc ? ResultIn : pc_reg);
  assign Stall  = ((state_reg == IDLE) & IRWrite) | ((state_reg == REQ) & ~MemReady) | fault_reg;
  assign PC     = pc_reg;
  assign Instr  = instr_reg;
  assign Fault  = fault_reg;

  instr_fields u_fields (
    .instr (instr_reg),
    .cond  (Cond),
    .op    (Op),
    .funct (Funct),
    .rn    (Rn),
    .rd    (Rd)
  );

endmodule
